// File: rtl/t_toggle_pulse_gen.sv
// t_toggle_pulse_gen: synchronizes and debounces a raw push-button level
// and emits a registered one-clock `t` pulse per accepted press.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-high reset, clears every flop
//   btn_in   - raw button level, asynchronous, may bounce
//   t        - registered one-cycle toggle request
//   pressed  - registered debounced button level
//
// Build option: define T_PULSE_AUTOREPEAT_EN to make `t` also pulse
// every REPEAT_CYCLES clocks while the button stays held.
module t_toggle_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;
  state_t                 state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_s = sync[SYNC_STAGES-1];

`ifdef T_PULSE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);

  // Repeat phase: value n mod REPEAT_CYCLES during HELD cycle n;
  // frozen while confirming a release.
  logic [RW-1:0] rcnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      t       <= 1'b0;
      pressed <= 1'b0;
`ifdef T_PULSE_AUTOREPEAT_EN
      rcnt    <= '0;
`endif
    end else begin
      t <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= CONFIRM_PRESS;
            cnt   <= CONE;
          end
        end
        CONFIRM_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CMAX) begin
            // Only this transition produces the press pulse.
            state   <= HELD;
            cnt     <= '0;
            t       <= 1'b1;
            pressed <= 1'b1;
`ifdef T_PULSE_AUTOREPEAT_EN
            rcnt    <= '0;
`endif
          end else begin
            cnt <= cnt + CONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= CONFIRM_RELEASE;
            cnt   <= CONE;
          end
`ifdef T_PULSE_AUTOREPEAT_EN
          else if (rcnt == RMAX) begin
            rcnt <= '0;
            t    <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
`endif
        end
        CONFIRM_RELEASE: begin
          if (btn_s) begin
            // Release glitch: back to HELD silently.
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CMAX) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + CONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
